int_ctl: RTL and testbench
==========================

Name: int_ctl

Overview:
- CPU-internal interrupt controller for device code 00. It decodes IOTs 6000-6007: SKON, ION, IOF, SRQ, GTF, RTF, SGT and CAF.
- Owns the interrupt-enable flag, the one-instruction ION/RTF delay, and the GT flag. Assembles the GTF word and generates skip/AC/link load strobes.
- Sits beside mem_ext and feeds int_ena/int_req to state_machine. It replaces the ad-hoc "clear int_ena on E1 with int_in_prog" logic.

Parameters:
- DEV_CODE, 6'o00, IOT device code this block responds to.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- state  in  5  CPU major/minor state (parameters.v encoding)
- instruction  in  [0:11]  current instruction register
- ac  in  [0:11]  accumulator
- link  in  1  current link bit
- dev_irq  in  1  OR of all peripheral interrupt requests
- UI  in  1  user-mode trap request from mem_ext
- int_inh  in  1  interrupt inhibit from mem_ext
- int_in_prog  in  1  interrupt cycle in progress, from state_machine
- sf  in  [0:6]  save field (UF,IF,DF) from mem_ext
- int_ena  out  1  interrupts enabled (ION flag)
- int_req  out  1  combined request to state_machine
- skip  out  1  skip strobe to PC logic
- ac_ld  out  1  load ac from gtf_bus
- gtf_bus  out  [0:11]  GTF word
- link_ld  out  1  load link from link_val
- link_val  out  1  link value for RTF
- gt  out  1  greater-than flag
- caf  out  1  clear-all-flags pulse to peripherals and mem_ext

Behaviour:
- Reset: int_ena=0, ion_pend=0, ion_arm=0, gt=0, skip=0, ac_ld=0, link_ld=0, caf=0.
- int_req = dev_irq | UI, combinational, not gated by int_ena. state_machine does the gating.
- Decode: instruction[0:2]=6, [3:8]=DEV_CODE, [9:11]=function.
- All actions commit on the clock edge where state==F2.
- Strobes (skip, ac_ld, link_ld, caf) are registered. Each is high exactly one cycle, during F3.
- gtf_bus is combinational, valid at all times:
  - bit0 = link
  - bit1 = gt
  - bit2 = int_req
  - bit3 = int_inh
  - bit4 = int_ena
  - bits5-11 = sf
- 6000 SKON: skip=int_ena; clears int_ena, ion_pend and ion_arm.
- 6001 ION: ion_pend<=1; int_ena is unchanged.
- 6002 IOF: clears int_ena, ion_pend and ion_arm.
- 6003 SRQ: skip=int_req.
- 6004 GTF: ac_ld=1. The AC receives gtf_bus as sampled at F2.
- 6005 RTF: link_val<=ac[0]; link_ld=1; gt<=ac[1]; ion_pend<=1. mem_ext restores UF/IF/DF itself.
- 6006 SGT: skip=gt.
- 6007 CAF:
  - clears int_ena, ion_pend, ion_arm and gt.
  - caf=1 for one cycle.
  - ac and link clearing is the datapath's job.
- ION delay (the instruction after ION/RTF always executes before an interrupt is accepted):
  - On a cycle with state==F0 and ion_pend=1: ion_pend<=0, ion_arm<=1.
  - On a cycle with state==F0 and ion_arm=1: ion_arm<=0, int_ena<=1.
  - Net effect: int_ena rises at F0 of the second instruction after ION/RTF.
- Interrupt acceptance: int_in_prog=1 on any cycle clears int_ena, ion_pend and ion_arm. This has priority over the ION delay.
- Simultaneous events:
  - Clear actions (IOF/SKON/CAF/int_in_prog) win over the ION delay setting int_ena.
  - ION executed while int_ena=1 keeps int_ena=1 throughout.
- Non-matching IOTs and non-IOT instructions: no state change, no strobes.
- Repeated ION (ION; ION): ion_pend re-set. int_ena rises at F0 of the second instruction following the last ION.
- Reset mid-delay: all flags cleared immediately (asynchronous).
- HALT/single-step: the delay counts only F0 cycles, so it stays correct across halts.

Decomposition:
- IOT function constants go in parameters.v alongside the state encodings: SKON=3'o0, ION=1, IOF=2, SRQ=3, GTF=4, RTF=5, SGT=6, CAF=7.
- Optional sub-module ion_delay: the 2-stage F0-counted enable pipeline, with set/clear inputs and int_ena output.
- Remaining logic: decode, GT flag and strobe registers in int_ctl.

Test Plan:
- ION then two NOPs (7000), dev_irq=0 -> int_ena=0 through the F0 of the first NOP. int_ena=1 from the F0 edge of the second NOP.
- int_ena=1, dev_irq=1 -> state_machine enters interrupt. Once int_in_prog=1, int_ena=0 on the next edge; bench no longer forces int_ena.
- Flags (link=1, gt=1, int_ena=1, int_inh=0, sf=7'o123), dev_irq=1, GTF -> ac_ld one cycle in F3, gtf_bus=12'o7323. The word 7323 breaks down as bits0-4 = 1,1,1,0,1 and sf=1010011.
- ac=12'o6000, RTF -> link_ld with link_val=1, gt=1, ion_pend=1. int_ena=1 after the following instruction's F0 sequence as in the first test.
- int_ena=1, SKON -> skip=1 in F3, int_ena=0. Repeat SKON -> skip=0.
- gt=1, ion_pend=1, CAF -> caf pulse, gt=0, int_ena stays 0 through 3 subsequent instructions. Then SGT -> skip=0 and SRQ with UI=1 -> skip=1.

Source files
------------

// File: rtl/int_ctl_pkg.sv
// Shared constants for the CPU interrupt controller: major/minor state
// encodings and the IOT function codes for device 00.
package int_ctl_pkg;

  localparam logic [4:0] F0 = 5'd0;
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] D0 = 5'd4;
  localparam logic [4:0] E0 = 5'd8;

  localparam logic [2:0] IOT_OP = 3'o6;

  typedef enum logic [2:0] {
    SKON = 3'o0,
    ION  = 3'o1,
    IOF  = 3'o2,
    SRQ  = 3'o3,
    GTF  = 3'o4,
    RTF  = 3'o5,
    SGT  = 3'o6,
    CAF  = 3'o7
  } iot_fn_e;

  function automatic logic iot_match(input logic [0:11] instr, input logic [5:0] dev);
    return (instr[0:2] == IOT_OP) && (instr[3:8] == dev);
  endfunction

endpackage

// File: rtl/int_ctl_ion_delay.sv
// Two-stage interrupt-enable pipeline advanced only on F0 cycles, so the
// instruction after ION/RTF always completes before interrupts are taken.
module int_ctl_ion_delay
  import int_ctl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic f0,
  input  logic set,
  input  logic clear,
  output logic int_ena
);

  logic ion_pend;
  logic ion_arm;

  // A new ION restarts the delay from scratch, so any arm in flight is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ion_pend <= 1'b0;
      ion_arm  <= 1'b0;
      int_ena  <= 1'b0;
    end else if (clear) begin
      ion_pend <= 1'b0;
      ion_arm  <= 1'b0;
      int_ena  <= 1'b0;
    end else if (set) begin
      ion_pend <= 1'b1;
      ion_arm  <= 1'b0;
    end else if (f0) begin
      ion_pend <= 1'b0;
      ion_arm  <= ion_pend;
      if (ion_arm) int_ena <= 1'b1;
    end
  end

endmodule

// File: rtl/int_ctl.sv
// CPU-internal interrupt controller: decodes device-00 IOTs, holds the GT
// flag and interrupt enable, assembles the GTF word and issues F3 strobes.
module int_ctl
  import int_ctl_pkg::*;
#(
  parameter logic [5:0] DEV_CODE = 6'o00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  state,
  input  logic [0:11] instruction,
  input  logic [0:11] ac,
  input  logic        link,
  input  logic        dev_irq,
  input  logic        UI,
  input  logic        int_inh,
  input  logic        int_in_prog,
  input  logic [0:6]  sf,
  output logic        int_ena,
  output logic        int_req,
  output logic        skip,
  output logic        ac_ld,
  output logic [0:11] gtf_bus,
  output logic        link_ld,
  output logic        link_val,
  output logic        gt,
  output logic        caf
);

  iot_fn_e fn;
  logic    commit;
  logic    ion_set;
  logic    ion_clr;
  logic    unused_ac;

  assign unused_ac = ^ac[2:11];

  assign fn      = iot_fn_e'(instruction[9:11]);
  assign commit  = (state == F2) && iot_match(instruction, DEV_CODE);
  assign int_req = dev_irq | UI;
  assign gtf_bus = {link, gt, int_req, int_inh, int_ena, sf};

  assign ion_set = commit && ((fn == ION) || (fn == RTF));
  assign ion_clr = int_in_prog ||
                   (commit && ((fn == SKON) || (fn == IOF) || (fn == CAF)));

  int_ctl_ion_delay u_ion_delay (
    .clk     (clk),
    .reset   (reset),
    .f0      (state == F0),
    .set     (ion_set),
    .clear   (ion_clr),
    .int_ena (int_ena)
  );

  // Strobes default low every cycle, so each lasts exactly the F3 after F2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip     <= 1'b0;
      ac_ld    <= 1'b0;
      link_ld  <= 1'b0;
      link_val <= 1'b0;
      gt       <= 1'b0;
      caf      <= 1'b0;
    end else begin
      skip    <= 1'b0;
      ac_ld   <= 1'b0;
      link_ld <= 1'b0;
      caf     <= 1'b0;
      if (commit) begin
        case (fn)
          SKON: skip <= int_ena;
          ION:  ;
          IOF:  ;
          SRQ:  skip <= int_req;
          GTF:  ac_ld <= 1'b1;
          RTF: begin
            link_val <= ac[0];
            link_ld  <= 1'b1;
            gt       <= ac[1];
          end
          SGT:  skip <= gt;
          CAF: begin
            gt  <= 1'b0;
            caf <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_int_ctl.sv
// Directed self-checking bench for int_ctl: steps instructions through
// F0..F3 and checks flags, strobes and the GTF word against hand values.
module tb_int_ctl;
  import int_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  state;
  logic [0:11] instruction;
  logic [0:11] ac;
  logic        link;
  logic        dev_irq;
  logic        UI;
  logic        int_inh;
  logic        int_in_prog;
  logic [0:6]  sf;
  logic        int_ena;
  logic        int_req;
  logic        skip;
  logic        ac_ld;
  logic [0:11] gtf_bus;
  logic        link_ld;
  logic        link_val;
  logic        gt;
  logic        caf;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctl #(.DEV_CODE(6'o00)) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .instruction (instruction),
    .ac          (ac),
    .link        (link),
    .dev_irq     (dev_irq),
    .UI          (UI),
    .int_inh     (int_inh),
    .int_in_prog (int_in_prog),
    .sf          (sf),
    .int_ena     (int_ena),
    .int_req     (int_req),
    .skip        (skip),
    .ac_ld       (ac_ld),
    .gtf_bus     (gtf_bus),
    .link_ld     (link_ld),
    .link_val    (link_val),
    .gt          (gt),
    .caf         (caf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %o, expected %o", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic [4:0] s);
    state = s;
    @(posedge clk);
    #1;
  endtask

  // Runs F0..F2 of an instruction; strobes are then visible (F3 timing).
  task automatic to_f3(input logic [11:0] instr);
    instruction = instr;
    cycle(F0);
    cycle(F1);
    cycle(F2);
    state = F3;
  endtask

  task automatic exec(input logic [11:0] instr);
    to_f3(instr);
    cycle(F3);
  endtask

  initial begin
    reset = 1'b1; state = D0; instruction = 12'o7000; ac = '0; link = 1'b0;
    dev_irq = 1'b0; UI = 1'b0; int_inh = 1'b0; int_in_prog = 1'b0; sf = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_flags", {6'b0, int_ena, gt, skip, ac_ld, link_ld, caf}, 12'o0);
    check("int_req_idle", {11'b0, int_req}, 12'o0);
    UI = 1'b1; #1 check("int_req_ui", {11'b0, int_req}, 12'o1);
    UI = 1'b0; dev_irq = 1'b1; #1 check("int_req_dev", {11'b0, int_req}, 12'o1);
    dev_irq = 1'b0;

    // ION then two NOPs
    exec(12'o6001);
    check("ion_no_ena", {11'b0, int_ena}, 12'o0);
    instruction = 12'o7000;
    cycle(F0); check("ion_nop1_f0", {11'b0, int_ena}, 12'o0);
    cycle(F1); cycle(F2); cycle(F3);
    check("ion_nop1_end", {11'b0, int_ena}, 12'o0);
    cycle(F0); check("ion_nop2_f0", {11'b0, int_ena}, 12'o1);
    cycle(F1); cycle(F2); cycle(F3);

    // interrupt acceptance
    dev_irq = 1'b1; int_in_prog = 1'b1;
    cycle(E0);
    check("intack_clear", {11'b0, int_ena}, 12'o0);
    int_in_prog = 1'b0; dev_irq = 1'b0;

    // RTF with ac=6000
    ac = 12'o6000;
    to_f3(12'o6005);
    check("rtf_strobe", {9'b0, link_ld, link_val, gt}, 12'o7);
    check("rtf_no_ena", {11'b0, int_ena}, 12'o0);
    cycle(F3);
    check("rtf_f3_end", {11'b0, link_ld}, 12'o0);
    instruction = 12'o7000;
    cycle(F0); check("rtf_nop1_f0", {11'b0, int_ena}, 12'o0);
    cycle(F1); cycle(F2); cycle(F3);
    cycle(F0); check("rtf_nop2_f0", {11'b0, int_ena}, 12'o1);
    cycle(F1); cycle(F2); cycle(F3);

    // GTF
    link = 1'b1; dev_irq = 1'b1; int_inh = 1'b0; sf = 7'o123;
    to_f3(12'o6004);
    check("gtf_ac_ld", {11'b0, ac_ld}, 12'o1);
    check("gtf_word", gtf_bus, 12'o7323);
    int_inh = 1'b1; #1 check("gtf_word_inh", gtf_bus, 12'o7723);
    int_inh = 1'b0;
    cycle(F3);
    check("gtf_ac_ld_end", {11'b0, ac_ld}, 12'o0);
    dev_irq = 1'b0; link = 1'b0;

    // ION while enabled stays enabled
    exec(12'o6001);
    check("ion_keep", {11'b0, int_ena}, 12'o1);
    exec(12'o7000);
    check("ion_keep_nop", {11'b0, int_ena}, 12'o1);

    // SKON twice
    to_f3(12'o6000);
    check("skon_skip", {11'b0, skip}, 12'o1);
    check("skon_clear", {11'b0, int_ena}, 12'o0);
    cycle(F3);
    check("skon_skip_end", {11'b0, skip}, 12'o0);
    to_f3(12'o6000);
    check("skon2_skip", {11'b0, skip}, 12'o0);
    cycle(F3);

    // IOF after enabling
    exec(12'o6001); exec(12'o7000); exec(12'o7000);
    check("iof_pre", {11'b0, int_ena}, 12'o1);
    exec(12'o6002);
    check("iof_clear", {11'b0, int_ena}, 12'o0);

    // CAF with gt=1 and ION pending
    check("caf_pre_gt", {11'b0, gt}, 12'o1);
    exec(12'o6001);
    to_f3(12'o6007);
    check("caf_pulse", {10'b0, caf, gt}, 12'o2);
    cycle(F3);
    check("caf_end", {11'b0, caf}, 12'o0);
    for (int i = 0; i < 3; i++) begin
      exec(12'o7000);
      check("caf_no_ena", {11'b0, int_ena}, 12'o0);
    end
    to_f3(12'o6006);
    check("sgt_skip", {11'b0, skip}, 12'o0);
    cycle(F3);
    UI = 1'b1;
    to_f3(12'o6003);
    check("srq_skip", {11'b0, skip}, 12'o1);
    cycle(F3);

    // other device code and non-IOT: no strobes
    to_f3(12'o6013);
    check("other_dev", {11'b0, skip}, 12'o0);
    cycle(F3);
    to_f3(12'o7003);
    check("non_iot", {11'b0, skip}, 12'o0);
    cycle(F3);
    UI = 1'b0;

    // reset mid-delay
    exec(12'o6001);
    instruction = 12'o7000;
    cycle(F0); cycle(F1);
    #2 reset = 1'b1; #1 reset = 1'b0;
    cycle(F2); cycle(F3);
    cycle(F0);
    check("reset_mid_delay", {11'b0, int_ena}, 12'o0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
